// File: rtl/structure1_pkg.sv
// Shared constants, derived widths and FSM state encoding for the structure1 classifier stages.
// Pure declarations: no logic, no latency, no flow control.
package structure1_pkg;

  localparam int SPECIES  = 42;
  localparam int FC2_IN   = 64;
  localparam int CLASSES  = 6;
  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int BIAS_W   = 16;
  localparam int ACC_W    = 24;

  // Unsigned data is widened by one bit so the multiply can stay signed.
  localparam int PROD_W   = DATA_W + 1 + WEIGHT_W;

  localparam int SAMPLE_W = $clog2(SPECIES);
  localparam int K_W      = $clog2(FC2_IN);
  localparam int CLASS_W  = $clog2(CLASSES);

  localparam int DADDR_W  = 14;
  localparam int WADDR_W  = 12;
  localparam int BADDR_W  = 4;
  localparam int RCLASS_W = 4;
  localparam int RADDR_W  = 6;
  localparam int SADDR_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    SCORE,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/structure1_fc2_argmax_if.sv
// FC2 stage bus: intermediate-RAM/weight/bias read ports and per-sample result outputs.
// master = classifier side; slave = memories and result consumer. FC2_SCORE_OUT_EN adds score debug signals.
interface structure1_fc2_argmax_if;
  import structure1_pkg::*;

  logic                       data_en;
  logic [DADDR_W-1:0]         data_addr;
  logic [DATA_W-1:0]          data_in;
  logic                       w_en;
  logic [WADDR_W-1:0]         w_addr;
  logic signed [WEIGHT_W-1:0] w_data;
  logic [BADDR_W-1:0]         b_addr;
  logic signed [BIAS_W-1:0]   b_data;
  logic [RCLASS_W-1:0]        result_class;
  logic                       result_valid;
  logic [RADDR_W-1:0]         result_addr;
  logic                       done;

`ifdef FC2_SCORE_OUT_EN
  logic                       score_valid;
  logic signed [ACC_W-1:0]    score;
  logic [SADDR_W-1:0]         score_addr;

  modport master (
    output data_en, data_addr, w_en, w_addr, b_addr,
    output result_class, result_valid, result_addr, done,
    output score_valid, score, score_addr,
    input  data_in, w_data, b_data
  );
  modport slave (
    input  data_en, data_addr, w_en, w_addr, b_addr,
    input  result_class, result_valid, result_addr, done,
    input  score_valid, score, score_addr,
    output data_in, w_data, b_data
  );
`else
  modport master (
    output data_en, data_addr, w_en, w_addr, b_addr,
    output result_class, result_valid, result_addr, done,
    input  data_in, w_data, b_data
  );
  modport slave (
    input  data_en, data_addr, w_en, w_addr, b_addr,
    input  result_class, result_valid, result_addr, done,
    output data_in, w_data, b_data
  );
`endif

endinterface

// File: rtl/structure1_fc2_mac.sv
// Signed MAC for one class score: load/accumulate of data*weight, then combinational bias add.
// Accumulator updates one cycle after acc_en inputs are presented; no backpressure.
module structure1_fc2_mac
  import structure1_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_en,
  input  logic                       acc_load,
  input  logic [DATA_W-1:0]          data_in,
  input  logic signed [WEIGHT_W-1:0] w_data,
  input  logic signed [BIAS_W-1:0]   b_data,
  output logic signed [ACC_W-1:0]    score
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod  = PROD_W'($signed({1'b0, data_in})) * PROD_W'(w_data);
  assign score = acc + ACC_W'(b_data);

  // Worst-case magnitude fits in ACC_W, so no saturation is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc_load ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/structure1_fc2_argmax.sv
// FC2 + arg-max: one class index per sample every 397 cycles; fixed-latency reads, no backpressure.
// Optional FC2_SCORE_OUT_EN exposes each biased class score (score_valid/score/score_addr).
module structure1_fc2_argmax
  import structure1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  structure1_fc2_argmax_if.master bus
);

  localparam logic [K_W-1:0]      K_LAST = K_W'(FC2_IN - 1);
  localparam logic [CLASS_W-1:0]  C_LAST = CLASS_W'(CLASSES - 1);
  localparam logic [SAMPLE_W-1:0] S_LAST = SAMPLE_W'(SPECIES - 1);

  state_t                  state, state_nxt;
  logic                    start_q, launch;
  logic [K_W-1:0]          k;
  logic [CLASS_W-1:0]      cls, best_class;
  logic [SAMPLE_W-1:0]     sample;
  logic                    mac_en_q, mac_first_q;
  logic signed [ACC_W-1:0] score, best_score;
  logic                    rd_en, emit, in_score;

  assign launch = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    emit      = 1'b0;
    in_score  = 1'b0;
    case (state)
      IDLE, DONE: if (launch) state_nxt = MAC;
      MAC: begin
        rd_en = 1'b1;
        if (k == K_LAST) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = SCORE;
      SCORE: begin
        in_score  = 1'b1;
        state_nxt = (cls == C_LAST) ? EMIT : MAC;
      end
      EMIT: begin
        emit      = 1'b1;
        state_nxt = (sample == S_LAST) ? DONE : MAC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      k           <= '0;
      cls         <= '0;
      sample      <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      best_score  <= '0;
      best_class  <= '0;
    end else begin
      start_q     <= start;
      // Read data lags the address by one cycle, so MAC control is delayed to match.
      mac_en_q    <= rd_en;
      mac_first_q <= rd_en && (k == '0);
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            k      <= '0;
            cls    <= '0;
            sample <= '0;
          end
        end
        MAC: k <= (k == K_LAST) ? '0 : k + 1'b1;
        SCORE: begin
          // Strict compare keeps the lowest class index on ties.
          if (cls == '0 || score > best_score) begin
            best_score <= score;
            best_class <= cls;
          end
          if (cls != C_LAST) cls <= cls + 1'b1;
        end
        EMIT: begin
          if (sample != S_LAST) begin
            sample <= sample + 1'b1;
            cls    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  structure1_fc2_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_en   (mac_en_q),
    .acc_load (mac_first_q),
    .data_in  (bus.data_in),
    .w_data   (bus.w_data),
    .b_data   (bus.b_data),
    .score    (score)
  );

  assign bus.data_en      = rd_en;
  assign bus.w_en         = rd_en;
  assign bus.data_addr    = DADDR_W'(sample) * DADDR_W'(FC2_IN) + DADDR_W'(k);
  assign bus.w_addr       = WADDR_W'(cls) * WADDR_W'(FC2_IN) + WADDR_W'(k);
  assign bus.b_addr       = BADDR_W'(cls);
  assign bus.result_valid = emit;
  assign bus.result_class = RCLASS_W'(best_class);
  assign bus.result_addr  = RADDR_W'(sample);
  assign bus.done         = (state == DONE);

`ifdef FC2_SCORE_OUT_EN
  assign bus.score_valid  = in_score;
  assign bus.score        = in_score ? score : '0;
  assign bus.score_addr   = SADDR_W'(sample) * SADDR_W'(CLASSES) + SADDR_W'(cls);
`endif

endmodule

// File: tb/tb_structure1_fc2_argmax.sv
// Directed bench for structure1_fc2_argmax: ROM/RAM models, result monitor, hand-computed expectations.
module tb_structure1_fc2_argmax;
  import structure1_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  structure1_fc2_argmax_if bus();

  structure1_fc2_argmax dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]        ram  [0:16383];
  logic signed [7:0] wrom [0:4095];
  logic signed [15:0] brom [0:15];

  always @(posedge clk) begin
    bus.data_in <= ram[bus.data_addr];
    bus.w_data  <= wrom[bus.w_addr];
    bus.b_data  <= brom[bus.b_addr];
  end

  int   cyc = 0;
  int   n_res = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cyc = 0;
  logic done_q = 1'b0;
  int   res_cls [256];
  int   res_addr[256];
  int   res_cyc [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    done_q <= bus.done;
    if (bus.done && !done_q) done_cyc <= cyc;
    if (bus.result_valid && n_res < 256) begin
      res_cls[n_res]  <= int'(bus.result_class);
      res_addr[n_res] <= int'(bus.result_addr);
      res_cyc[n_res]  <= cyc;
      n_res           <= n_res + 1;
    end
  end

`ifdef FC2_SCORE_OUT_EN
  logic sc_on = 1'b0;
  int   n_sc = 0;
  int   sc_val [512];
  int   sc_addr[512];

  always @(negedge clk) begin
    if (sc_on && bus.score_valid && n_sc < 512) begin
      sc_val[n_sc]  <= int'(bus.score);
      sc_addr[n_sc] <= int'(bus.score_addr);
      n_sc          <= n_sc + 1;
    end
  end
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < SPECIES * FC2_IN; i++) ram[i] = (mode == 2) ? 8'd255 : 8'd1;
    for (int c = 0; c < CLASSES; c++) begin
      for (int j = 0; j < FC2_IN; j++) begin
        case (mode)
          0:       wrom[c*FC2_IN + j] = 8'(c);
          1:       wrom[c*FC2_IN + j] = 8'h00;
          default: wrom[c*FC2_IN + j] = (c == 0) ? 8'h80 : 8'h00;
        endcase
      end
    end
    for (int c = 0; c < 16; c++) begin
      case (mode)
        0:       brom[c] = 16'sd0;
        1:       brom[c] = 16'sd5;
        default: brom[c] = (c == 3) ? 16'sd1 : 16'sd0;
      endcase
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_res(input int target, input int budget);
    int t = 0;
    while (n_res < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (n_res < target) chk("result_timeout", n_res, target);
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data_en"},      int'(bus.data_en), 0);
    chk({tag, "_w_en"},         int'(bus.w_en), 0);
    chk({tag, "_data_addr"},    int'(bus.data_addr), 0);
    chk({tag, "_w_addr"},       int'(bus.w_addr), 0);
    chk({tag, "_b_addr"},       int'(bus.b_addr), 0);
    chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
    chk({tag, "_result_class"}, int'(bus.result_class), 0);
    chk({tag, "_result_addr"},  int'(bus.result_addr), 0);
    chk({tag, "_done"},         int'(bus.done), 0);
  endtask

  int base, n0, good;
`ifdef FC2_SCORE_OUT_EN
  int sbase;
`endif

  initial begin
    // Reset state; start is already high so release must launch immediately.
    load(0);
    start = 1'b1;
    #12;
    chk_outputs_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    base  = n_res;
    n0    = cyc;
`ifdef FC2_SCORE_OUT_EN
    sc_on = 1'b1;
`endif
    wait_res(base + SPECIES, 20000);
    wait_cyc(3);
    chk("run1_first_latency", res_cyc[base] - n0, 397);
    for (int i = 0; i < SPECIES; i++) begin
      chk($sformatf("run1_class_%0d", i), res_cls[base+i], 5);
      chk($sformatf("run1_addr_%0d", i), res_addr[base+i], i);
      if (i > 0) chk($sformatf("run1_gap_%0d", i), res_cyc[base+i] - res_cyc[base+i-1], 397);
    end
    chk("run1_done", int'(bus.done), 1);
    chk("run1_done_cycle", done_cyc - n0, 16675);
`ifdef FC2_SCORE_OUT_EN
    sc_on = 1'b0;
    @(negedge clk);
    chk("score_count", n_sc, 252);
    for (int i = 0; i < 252; i++) begin
      chk($sformatf("score_addr_%0d", i), sc_addr[i], i);
      chk($sformatf("score_val_%0d", i), sc_val[i], 64 * (i % 6));
    end
`endif

    // start held high after DONE must not relaunch
    wait_cyc(500);
    chk("hold_no_result", n_res, base + SPECIES);
    chk("hold_data_en", int'(bus.data_en), 0);
    chk("hold_done", int'(bus.done), 1);

    // Low/high pulse relaunches an identical run and clears done
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base  = n_res;
    n0    = cyc;
    wait_cyc(3);
    chk("run2_done_cleared", int'(bus.done), 0);
    wait_res(base + SPECIES, 20000);
    wait_cyc(3);
    good = 0;
    for (int i = 0; i < SPECIES; i++)
      if (res_cls[base+i] == 5 && res_addr[base+i] == i) good++;
    chk("run2_results_ok", good, SPECIES);
    chk("run2_first_latency", res_cyc[base] - n0, 397);
    chk("run2_done", int'(bus.done), 1);

    // Equal scores: tie resolves to class 0
    rst_n = 1'b0;
    start = 1'b0;
    load(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    base  = n_res;
    wait_res(base + 3, 2000);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tie_class_%0d", i), res_cls[base+i], 0);
      chk($sformatf("tie_addr_%0d", i), res_addr[base+i], i);
    end

    // Large negative class 0, class 3 wins by bias alone
    rst_n = 1'b0;
    start = 1'b0;
    load(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    base  = n_res;
`ifdef FC2_SCORE_OUT_EN
    sbase = n_sc;
    sc_on = 1'b1;
`endif
    wait_res(base + 2, 2000);
    chk("neg_class_0", res_cls[base], 3);
    chk("neg_class_1", res_cls[base+1], 3);
`ifdef FC2_SCORE_OUT_EN
    sc_on = 1'b0;
    chk("neg_score_c0", sc_val[sbase], -2088960);
    chk("neg_score_c3", sc_val[sbase+3], 1);
`endif

    // Reset in the middle of sample 10
    rst_n = 1'b0;
    start = 1'b0;
    load(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    base  = n_res;
    wait_res(base + 10, 5000);
    wait_cyc(100);
    chk("mid_data_addr_live", int'(bus.data_addr) / FC2_IN, 10);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("idle_no_result", n_res, base + 10);
    chk("idle_data_en", int'(bus.data_en), 0);
    start = 1'b1;
    base  = n_res;
    n0    = cyc;
    wait_res(base + 2, 2000);
    chk("restart_addr_0", res_addr[base], 0);
    chk("restart_class_0", res_cls[base], 5);
    chk("restart_addr_1", res_addr[base+1], 1);
    chk("restart_latency", res_cyc[base] - n0, 397);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
